// File: rtl/piece_writer_if.sv
// piece_writer_if: request/response and board-RAM write port of the piece writer.
interface piece_writer_if;
  logic       start;
  logic       erase;
  logic [4:0] X_anchor;
  logic [5:0] Y_anchor;
  logic [3:0] block;
  logic [7:0] ram_addr;
  logic [5:0] ram_D;
  logic       ram_wren;
  logic       busy;
  logic       done;
  logic       oob;
  modport master (
    output start, erase, X_anchor, Y_anchor, block,
    input  ram_addr, ram_D, ram_wren, busy, done, oob
  );
  modport slave (
    input  start, erase, X_anchor, Y_anchor, block,
    output ram_addr, ram_D, ram_wren, busy, done, oob
  );
endinterface

// File: rtl/piece_writer.sv
// piece_writer: writes the four cells of a tetromino into the board RAM, one cell per clock.
module piece_writer #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 24
) (
  input logic          clk,
  input logic          reset,
  piece_writer_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;
  localparam logic [7:0] W = 8'(BOARD_W);
  localparam logic [7:0] H = 8'(BOARD_H);
  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic       erase_q;
  logic [4:0] x_q;
  logic [5:0] y_q;
  logic [3:0] block_q;
  logic [7:0] coord_x, coord_y, cx, cy, addr_n;
  logic [5:0] colour, d_n;
  logic       in_range, load, wren_n, busy_n, done_n, oob_n;
  lut u_lut (
    .block   (block_q),
    .rot     (2'b00),
    .coord_x (coord_x),
    .coord_y (coord_y),
    .colour  (colour)
  );
  // zero-extended so an anchor near the edge lands past the board instead of wrapping
  assign cx = {3'b0, x_q} + {6'b0, coord_x[{cnt, 1'b0} +: 2]};
  assign cy = {2'b0, y_q} + {6'b0, coord_y[{cnt, 1'b0} +: 2]};
  assign in_range = (cx < W) && (cy < H);
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    addr_n  = '0;
    d_n     = '0;
    wren_n  = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;
    oob_n   = bus.oob;
    case (state)
      IDLE: if (bus.start) begin
        state_n = WRITE;
        cnt_n   = '0;
        load    = 1'b1;
        oob_n   = 1'b0;
      end
      WRITE: begin
        state_n = (cnt == 2'd3) ? DONE : WRITE;
        cnt_n   = cnt + 2'd1;
        busy_n  = 1'b1;
        wren_n  = in_range;
        addr_n  = in_range ? cy * W + cx : '0;
        d_n     = erase_q ? '0 : colour;
        oob_n   = bus.oob | ~in_range;
      end
      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b1;
        done_n  = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      erase_q      <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      block_q      <= '0;
      bus.ram_addr <= '0;
      bus.ram_D    <= '0;
      bus.ram_wren <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.oob      <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      bus.ram_addr <= addr_n;
      bus.ram_D    <= d_n;
      bus.ram_wren <= wren_n;
      bus.busy     <= busy_n;
      bus.done     <= done_n;
      bus.oob      <= oob_n;
      if (load) begin
        erase_q <= bus.erase;
        x_q     <= bus.X_anchor;
        y_q     <= bus.Y_anchor;
        block_q <= bus.block;
      end
    end
  end
endmodule

module lut (
  input  logic [3:0] block,
  input  logic [1:0] rot,
  output logic [7:0] coord_x,
  output logic [7:0] coord_y,
  output logic [5:0] colour
);
  logic [7:0] bx, by;
  always_comb begin
    case (block)
      4'd0:    {bx, by, colour} = {8'h44, 8'h50, 6'h2A};
      4'd1:    {bx, by, colour} = {8'hE4, 8'h00, 6'h0F};
      4'd2:    {bx, by, colour} = {8'h64, 8'h40, 6'h33};
      4'd3:    {bx, by, colour} = {8'h49, 8'h50, 6'h0C};
      4'd4:    {bx, by, colour} = {8'h94, 8'h50, 6'h30};
      4'd5:    {bx, by, colour} = {8'h90, 8'h54, 6'h03};
      4'd6:    {bx, by, colour} = {8'h92, 8'h54, 6'h3C};
      default: {bx, by, colour} = {8'h00, 8'h00, 6'h3F};
    endcase
  end
  // quarter turns inside the 4x4 bounding box
  for (genvar c = 0; c < 4; c++) begin : g_rot
    logic [1:0] x, y;
    assign x = bx[2*c +: 2];
    assign y = by[2*c +: 2];
    assign coord_x[2*c +: 2] = rot == 2'd0 ? x : rot == 2'd1 ? ~y : rot == 2'd2 ? ~x : y;
    assign coord_y[2*c +: 2] = rot == 2'd0 ? y : rot == 2'd1 ? x : rot == 2'd2 ? ~y : ~x;
  end
endmodule
